// File: rtl/lbp_host_mem_pkg.sv
// rtl/lbp_host_mem_pkg.sv - shared geometry and state encodings for lbp_host_mem
package lbp_host_mem_pkg;

    localparam int IMG_W = 128;
    localparam int LOG_W = $clog2(IMG_W);
    localparam int AW    = 2 * LOG_W;
    localparam int DEPTH = IMG_W * IMG_W;

    typedef enum logic [1:0] {
        S_LOAD  = 2'd0,
        S_SERVE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    // Address is {row,col}; a pixel is on the border when row or col is 0 or IMG_W-1.
    function automatic logic is_border(input logic [AW-1:0] addr);
        logic [LOG_W-1:0] row;
        logic [LOG_W-1:0] col;
        row = addr[AW-1:LOG_W];
        col = addr[LOG_W-1:0];
        return (row == '0) || (row == '1) || (col == '0) || (col == '1);
    endfunction

endpackage

// File: rtl/lbp_img_ram.sv
// rtl/lbp_img_ram.sv - image RAM, asynchronous read, synchronous write
module lbp_img_ram
    import lbp_host_mem_pkg::*;
(
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);

    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/lbp_host_mem.sv
// rtl/lbp_host_mem.sv - host memory responder: gray image loader/server and LBP result capture
module lbp_host_mem
    import lbp_host_mem_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          load_valid,
    input  logic [7:0]    load_data,
    output logic          load_ready,
    output logic          gray_ready,
    input  logic          gray_req,
    input  logic [AW-1:0] gray_addr,
    output logic [7:0]    gray_data,
    input  logic          lbp_valid,
    input  logic [AW-1:0] lbp_addr,
    input  logic [7:0]    lbp_data,
    input  logic          finish,
    output logic          done,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data,
    output logic [AW-1:0] wr_count,
    output logic          err
);

    state_t        state;
    state_t        state_next;
    logic [AW-1:0] ptr;
    logic          in_load;
    logic          in_serve;
    logic          in_done;
    logic          load_beat;
    logic          serve_wr;
    logic          res_we;
    logic [AW-1:0] res_waddr;
    logic [7:0]    res_wdata;
    logic [7:0]    gray_rd;
    logic [7:0]    res_rd;
    logic          err_set;

    assign in_load   = (state == S_LOAD);
    assign in_serve  = (state == S_SERVE);
    assign in_done   = (state == S_DONE);
    assign load_beat = in_load && load_valid;
    assign serve_wr  = in_serve && lbp_valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_LOAD;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_LOAD:  if (load_beat && (ptr == '1)) state_next = S_SERVE;
            S_SERVE: if (finish) state_next = S_DONE;
            S_DONE:  state_next = S_DONE;
            default: state_next = S_LOAD;
        endcase
    end

    // Loading also zeroes the result image so pixels the engine never writes read back as 0.
    assign res_we    = load_beat || serve_wr;
    assign res_waddr = in_load ? ptr : lbp_addr;
    assign res_wdata = in_load ? 8'h00 : lbp_data;

    lbp_img_ram u_gray_ram (
        .clk   (clk),
        .we    (load_beat),
        .waddr (ptr),
        .wdata (load_data),
        .raddr (gray_addr),
        .rdata (gray_rd)
    );

    lbp_img_ram u_res_ram (
        .clk   (clk),
        .we    (res_we),
        .waddr (res_waddr),
        .wdata (res_wdata),
        .raddr (rd_addr),
        .rdata (res_rd)
    );

    assign err_set = (lbp_valid && !in_serve)
                  || (serve_wr && is_border(lbp_addr))
                  || (gray_req && !in_serve)
                  || (finish && in_load);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr      <= '0;
            wr_count <= '0;
            err      <= 1'b0;
        end else begin
            if (load_beat) begin
                ptr <= ptr + 1'b1;
            end
            if (serve_wr && (wr_count != '1)) begin
                wr_count <= wr_count + 1'b1;
            end
            if (err_set) begin
                err <= 1'b1;
            end
        end
    end

    assign load_ready = in_load;
    assign gray_ready = in_serve;
    assign done       = in_done;
    assign gray_data  = (in_serve && gray_req) ? gray_rd : 8'h00;
    assign rd_data    = in_done ? res_rd : 8'h00;

endmodule

// File: tb/tb_lbp_host_mem.sv
// tb/tb_lbp_host_mem.sv - directed self-checking bench for lbp_host_mem
module tb_lbp_host_mem;
    import lbp_host_mem_pkg::*;

    logic          clk;
    logic          reset;
    logic          load_valid;
    logic [7:0]    load_data;
    logic          load_ready;
    logic          gray_ready;
    logic          gray_req;
    logic [AW-1:0] gray_addr;
    logic [7:0]    gray_data;
    logic          lbp_valid;
    logic [AW-1:0] lbp_addr;
    logic [7:0]    lbp_data;
    logic          finish;
    logic          done;
    logic [AW-1:0] rd_addr;
    logic [7:0]    rd_data;
    logic [AW-1:0] wr_count;
    logic          err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic          req;
        logic [AW-1:0] addr;
        logic [7:0]    exp;
    } gray_vec_t;

    typedef struct {
        logic [AW-1:0] addr;
        logic [7:0]    exp;
    } rd_vec_t;

    gray_vec_t gv[6];
    rd_vec_t   rv_a[5];

    lbp_host_mem dut (
        .clk        (clk),
        .reset      (reset),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_ready (load_ready),
        .gray_ready (gray_ready),
        .gray_req   (gray_req),
        .gray_addr  (gray_addr),
        .gray_data  (gray_data),
        .lbp_valid  (lbp_valid),
        .lbp_addr   (lbp_addr),
        .lbp_data   (lbp_data),
        .finish     (finish),
        .done       (done),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .wr_count   (wr_count),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        load_valid = 1'b0;
        load_data  = 8'h00;
        gray_req   = 1'b0;
        gray_addr  = '0;
        lbp_valid  = 1'b0;
        lbp_addr   = '0;
        lbp_data   = 8'h00;
        finish     = 1'b0;
        rd_addr    = '0;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic write_lbp(input logic [AW-1:0] a, input logic [7:0] d);
        lbp_valid = 1'b1;
        lbp_addr  = a;
        lbp_data  = d;
        tick();
        lbp_valid = 1'b0;
    endtask

    // gray[k] = k[7:0]; optional idle gap at k==100 and a stray result write at k==200.
    task automatic load_image(input bit gap, input bit stray);
        for (int k = 0; k < DEPTH; k++) begin
            if (gap && k == 100) begin
                load_valid = 1'b0;
                tick();
            end
            load_valid = 1'b1;
            load_data  = 8'(k);
            if (stray && k == 200) begin
                lbp_valid = 1'b1;
                lbp_addr  = AW'(50);
                lbp_data  = 8'h77;
            end
            tick();
            lbp_valid = 1'b0;
            if (k == DEPTH - 2) check("load_ready_before_last_beat", 32'(load_ready), 32'd1);
        end
        load_valid = 1'b0;
    endtask

    initial begin
        gv[0] = '{1'b1, AW'(129),   8'h81};
        gv[1] = '{1'b1, AW'(0),     8'h00};
        gv[2] = '{1'b1, AW'(16383), 8'hFF};
        gv[3] = '{1'b1, AW'(300),   8'h2C};
        gv[4] = '{1'b0, AW'(129),   8'h00};
        gv[5] = '{1'b1, AW'(101),   8'h65};

        rv_a[0] = '{AW'(130),  8'hA5};
        rv_a[1] = '{AW'(127),  8'h11};
        rv_a[2] = '{AW'(0),    8'h00};
        rv_a[3] = '{AW'(5000), 8'h00};
        rv_a[4] = '{AW'(131),  8'h00};

        idle_inputs();
        reset = 1'b1;
        #12;
        check("rst_load_ready", 32'(load_ready), 32'd1);
        check("rst_gray_ready", 32'(gray_ready), 32'd0);
        check("rst_done",       32'(done),       32'd0);
        check("rst_wr_count",   32'(wr_count),   32'd0);
        check("rst_err",        32'(err),        32'd0);
        check("rst_rd_data",    32'(rd_data),    32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Protocol errors while still loading
        lbp_valid = 1'b1; lbp_addr = AW'(300); lbp_data = 8'h77;
        tick();
        lbp_valid = 1'b0;
        check("lbp_in_load_err", 32'(err), 32'd1);
        pulse_reset();
        check("err_cleared_by_reset", 32'(err), 32'd0);
        gray_req = 1'b1; gray_addr = AW'(129);
        #1;
        check("gray_data_in_load", 32'(gray_data), 32'd0);
        tick();
        gray_req = 1'b0;
        check("gray_req_in_load_err", 32'(err), 32'd1);
        pulse_reset();
        finish = 1'b1;
        tick();
        finish = 1'b0;
        check("finish_in_load_err", 32'(err), 32'd1);
        check("finish_in_load_ignored", 32'(load_ready), 32'd1);
        pulse_reset();

        // Image A: reads, border and interior writes, finish, readback
        load_image(1'b1, 1'b0);
        check("A_load_ready", 32'(load_ready), 32'd0);
        check("A_gray_ready", 32'(gray_ready), 32'd1);
        check("A_err_clean",  32'(err),        32'd0);
        for (int i = 0; i < 6; i++) begin
            gray_req  = gv[i].req;
            gray_addr = gv[i].addr;
            #1;
            check($sformatf("A_gray_rd_%0d", i), 32'(gray_data), 32'(gv[i].exp));
        end
        gray_req = 1'b0;
        write_lbp(AW'(130), 8'hA5);
        check("A_interior_no_err", 32'(err), 32'd0);
        write_lbp(AW'(127), 8'h11);
        check("A_border_err", 32'(err), 32'd1);
        check("A_wr_count", 32'(wr_count), 32'd2);
        rd_addr = AW'(130);
        #1;
        check("A_rd_gated_in_serve", 32'(rd_data), 32'd0);
        finish = 1'b1;
        tick();
        finish = 1'b0;
        check("A_done", 32'(done), 32'd1);
        check("A_gray_ready_done", 32'(gray_ready), 32'd0);
        for (int i = 0; i < 5; i++) begin
            rd_addr = rv_a[i].addr;
            #1;
            check($sformatf("A_readback_%0d", i), 32'(rd_data), 32'(rv_a[i].exp));
        end
        lbp_valid = 1'b1; lbp_addr = AW'(130); lbp_data = 8'h5A;
        tick();
        lbp_valid = 1'b0;
        rd_addr = AW'(130);
        #1;
        check("A_write_in_done_dropped", 32'(rd_data), 32'hA5);
        check("A_wr_count_frozen", 32'(wr_count), 32'd2);
        gray_req = 1'b1; gray_addr = AW'(129);
        #1;
        check("A_gray_in_done", 32'(gray_data), 32'd0);
        gray_req = 1'b0;

        // Image B: stray write during load, write coinciding with finish
        pulse_reset();
        load_image(1'b0, 1'b1);
        check("B_stray_err", 32'(err), 32'd1);
        lbp_valid = 1'b1; lbp_addr = AW'(200); lbp_data = 8'h3C; finish = 1'b1;
        #1;
        check("B_done_not_yet", 32'(done), 32'd0);
        tick();
        lbp_valid = 1'b0; finish = 1'b0;
        check("B_done", 32'(done), 32'd1);
        check("B_wr_count", 32'(wr_count), 32'd1);
        rd_addr = AW'(200);
        #1;
        check("B_rd_200", 32'(rd_data), 32'h3C);
        rd_addr = AW'(50);
        #1;
        check("B_stray_not_stored", 32'(rd_data), 32'd0);
        rd_addr = AW'(130);
        #1;
        check("B_reload_cleared", 32'(rd_data), 32'd0);

        // Image C: back-to-back writes then reset mid-SERVE
        pulse_reset();
        load_image(1'b0, 1'b0);
        lbp_valid = 1'b1; lbp_addr = AW'(127); lbp_data = 8'h01;
        tick();
        lbp_addr = AW'(131); lbp_data = 8'h02;
        tick();
        lbp_valid = 1'b0;
        check("C_wr_count_b2b", 32'(wr_count), 32'd2);
        check("C_err_border", 32'(err), 32'd1);
        reset = 1'b1;
        #1;
        check("C_rst_load_ready", 32'(load_ready), 32'd1);
        check("C_rst_gray_ready", 32'(gray_ready), 32'd0);
        check("C_rst_wr_count",   32'(wr_count),   32'd0);
        check("C_rst_err",        32'(err),        32'd0);
        tick();
        reset = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
